// File: rtl/serial_word_capture_pkg.sv
// ============================================================================
// serial_word_capture_pkg
// Shared sizes, capture state encoding and reference test patterns.
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_word_capture_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   localparam logic [DEF_WIDTH-1:0] PAT_CC = 8'hCC;
   localparam logic [DEF_WIDTH-1:0] PAT_AA = 8'hAA;

   typedef enum logic [0:0] {
      ST_CAPTURE = 1'b0,
      ST_FULL    = 1'b1
   } cap_state_e;

   // Word counter must represent 0..depth inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_word_capture_if.sv
// ============================================================================
// serial_word_capture_if
// Serial input, read port and status bundle of the word capture block.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface serial_word_capture_if
   import serial_word_capture_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);

   localparam int ADDR_W  = $clog2(DEPTH);
   localparam int COUNT_W = count_width(DEPTH);

   logic               in_bit;
   logic               in_valid;
   logic [ADDR_W-1:0]  rd_addr;
   logic [WIDTH-1:0]   rd_data;
   logic               word_valid;
   logic [WIDTH-1:0]   word_data;
   logic [COUNT_W-1:0] word_count;
   logic               full;

   modport master (
      output in_bit, in_valid, rd_addr,
      input  rd_data, word_valid, word_data, word_count, full
   );

   modport slave (
      input  in_bit, in_valid, rd_addr,
      output rd_data, word_valid, word_data, word_count, full
   );

endinterface

`default_nettype wire

// File: rtl/serial_word_capture_mem.sv
// ============================================================================
// capture_mem
// Synchronous-write, registered-read memory with synchronous clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module capture_mem #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  wire logic              clk,
   input  wire logic              clear,
   input  wire logic              we_i,
   input  wire logic [ADDR_W-1:0] wr_addr_i,
   input  wire logic [WIDTH-1:0]  wr_data_i,
   input  wire logic [ADDR_W-1:0] rd_addr_i,
   output logic      [WIDTH-1:0]  rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Non-blocking read of mem_q gives read-before-write on address collision.
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem_q[rd_addr_i];
         if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
         end
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/serial_word_capture.sv
// ============================================================================
// serial_word_capture
// LSB-first serial-to-word deserializer feeding a capture memory.
// Build option: SERIAL_CAPTURE_WRAP_EN (wrap and overwrite instead of stop).
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_word_capture
   import serial_word_capture_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  wire logic              clk,
   input  wire logic              clear,
   serial_word_capture_if.slave   bus
);

   localparam int CNT_W   = $clog2(WIDTH);
   localparam int ADDR_W  = $clog2(DEPTH);
   localparam int COUNT_W = count_width(DEPTH);

   cap_state_e         state_q, state_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic               word_valid_q, word_valid_d;
   logic [WIDTH-1:0]   word_data_q, word_data_d;
   logic [COUNT_W-1:0] word_count_q, word_count_d;
   logic               mem_we;

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q      <= ST_CAPTURE;
         bit_cnt_q    <= '0;
         wr_addr_q    <= '0;
         shift_q      <= '0;
         word_valid_q <= 1'b0;
         word_data_q  <= '0;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         wr_addr_q    <= wr_addr_d;
         shift_q      <= shift_d;
         word_valid_q <= word_valid_d;
         word_data_q  <= word_data_d;
         word_count_q <= word_count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      wr_addr_d    = wr_addr_q;
      shift_d      = shift_q;
      word_valid_d = 1'b0;
      word_data_d  = word_data_q;
      word_count_d = word_count_q;
      mem_we       = 1'b0;

      if (state_q == ST_CAPTURE && bus.in_valid) begin
         shift_d[bit_cnt_q] = bus.in_bit;
         bit_cnt_d          = bit_cnt_q + CNT_W'(1);
         if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
            mem_we       = 1'b1;
            word_data_d  = shift_d;
            word_valid_d = 1'b1;
            wr_addr_d    = wr_addr_q + ADDR_W'(1);
`ifdef SERIAL_CAPTURE_WRAP_EN
            if (word_count_q != COUNT_W'(DEPTH)) begin
               word_count_d = word_count_q + COUNT_W'(1);
            end
`else
            word_count_d = word_count_q + COUNT_W'(1);
            if (word_count_q == COUNT_W'(DEPTH - 1)) begin
               state_d = ST_FULL;
            end
`endif
         end
      end
   end

   capture_mem #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk       (clk),
      .clear     (clear),
      .we_i      (mem_we),
      .wr_addr_i (wr_addr_q),
      .wr_data_i (shift_d),
      .rd_addr_i (bus.rd_addr),
      .rd_data_o (bus.rd_data)
   );

   assign bus.word_valid = word_valid_q;
   assign bus.word_data  = word_data_q;
   assign bus.word_count = word_count_q;
   assign bus.full       = (state_q == ST_FULL);

endmodule

`default_nettype wire

// File: tb/tb_serial_word_capture.sv
// ============================================================================
// tb_serial_word_capture
// Directed and randomized bench for serial_word_capture with a word-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_word_capture;
   import serial_word_capture_pkg::*;

   logic clk;
   logic clear;

   serial_word_capture_if #(.WIDTH(8), .DEPTH(16)) bus ();

   serial_word_capture #(.WIDTH(8), .DEPTH(16)) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: list of stored words, bits of the word in progress.
   logic [7:0] m_mem [16];
   int         m_count;
   int         m_wr;
   int         m_nbits;
   logic [7:0] m_acc;
   logic       m_full;
   logic       m_exp_valid;
   logic [7:0] m_wdata;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input logic [7:0] exp_rd);
      chk("word_valid", {7'd0, bus.word_valid}, {7'd0, m_exp_valid});
      chk("word_data",  bus.word_data, m_wdata);
      chk("word_count", {3'd0, bus.word_count}, 8'(m_count));
      chk("full",       {7'd0, bus.full}, {7'd0, m_full});
      chk("rd_data",    bus.rd_data, exp_rd);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_count     = 0;
      m_wr        = 0;
      m_nbits     = 0;
      m_acc       = 8'h00;
      m_full      = 1'b0;
      m_exp_valid = 1'b0;
      m_wdata     = 8'h00;
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'($urandom);
      bus.rd_addr  = 4'($urandom);
      model_reset();
      @(posedge clk);
      #1;
      check_all(8'h00);
      clear = 1'b0;
   endtask

   task automatic step(input logic b, input logic v, input logic [3:0] ra);
      logic [7:0] exp_rd;
      @(negedge clk);
      bus.in_bit   = b;
      bus.in_valid = v;
      bus.rd_addr  = ra;
      exp_rd       = m_mem[ra];
      m_exp_valid  = 1'b0;
      if (v && !m_full) begin
         m_acc[m_nbits] = b;
         m_nbits++;
         if (m_nbits == 8) begin
            m_mem[m_wr] = m_acc;
            m_wdata     = m_acc;
            m_exp_valid = 1'b1;
            m_wr        = (m_wr + 1) % 16;
            m_nbits     = 0;
            if (m_count < 16) m_count++;
`ifndef SERIAL_CAPTURE_WRAP_EN
            if (m_count == 16) m_full = 1'b1;
`endif
         end
      end
      @(posedge clk);
      #1;
      check_all(exp_rd);
   endtask

   // Sends a word LSB first; gap_len idle cycles follow bit index gap_after.
   task automatic send_word(input logic [7:0] w, input int gap_after, input int gap_len,
                            input int ra);
      logic [3:0] a;
      for (int i = 0; i < 8; i++) begin
         a = (ra < 0) ? 4'($urandom) : 4'(ra);
         step(w[i], 1'b1, a);
         if (i == gap_after) begin
            for (int g = 0; g < gap_len; g++) begin
               a = (ra < 0) ? 4'($urandom) : 4'(ra);
               step(1'($urandom), 1'b0, a);
            end
         end
      end
   endtask

   task automatic idle(input int n, input int ra);
      for (int i = 0; i < n; i++) begin
         step(1'($urandom), 1'b0, (ra < 0) ? 4'($urandom) : 4'(ra));
      end
   endtask

   initial begin
      clear        = 1'b1;
      bus.in_bit   = 1'b0;
      bus.in_valid = 1'b0;
      bus.rd_addr  = 4'd0;
      model_reset();

      // Reset state, then a single CC word and its read-back.
      do_clear();
      send_word(PAT_CC, -1, 0, -1);
      idle(2, 0);

      // Alternating CC/AA up to the capacity, then one extra 5A word.
      do_clear();
      for (int k = 0; k < 16; k++) begin
         send_word((k % 2 == 0) ? PAT_CC : PAT_AA, -1, 0, -1);
      end
      send_word(8'h5A, -1, 0, -1);
      for (int i = 0; i < 12; i++) step(1'($urandom), 1'b1, 4'($urandom));
      for (int a = 0; a < 16; a++) step(1'b0, 1'b0, 4'(a));
      idle(1, 0);

      // Gap of 3 idle cycles after bit 4 delays the pulse by 3 cycles.
      do_clear();
      send_word(PAT_AA, 4, 3, -1);
      idle(2, 0);

      // Clear after 5 bits discards the partial word.
      do_clear();
      for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, 4'($urandom));
      do_clear();
      send_word(PAT_AA, -1, 0, -1);
      idle(2, 0);

      // Read of address 1 collides with its write: old value first.
      do_clear();
      send_word(PAT_CC, -1, 0, 1);
      send_word(PAT_AA, -1, 0, 1);
      idle(2, 1);

      // Randomized words with random gaps and random read addresses.
      for (int r = 0; r < 3; r++) begin
         do_clear();
         for (int k = 0; k < 20; k++) begin
            send_word(8'($urandom), $urandom_range(0, 7), $urandom_range(0, 3), -1);
         end
         for (int a = 0; a < 16; a++) step(1'($urandom), 1'($urandom), 4'(a));
         idle(1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
